// File: rtl/rd_sched_pkg.sv
// ----------------------------------------------------------------------------
// rd_sched_pkg: shared read-scheduler queue sizing and vector types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rd_sched_pkg;
  localparam int QUEUE_NUM   = 8;
  localparam int PEND_CNT_W  = 4;
  localparam int QUEUE_IDX_W = $clog2(QUEUE_NUM);

  typedef logic [QUEUE_IDX_W-1:0] queue_idx_t;
  typedef logic [QUEUE_NUM-1:0]   queue_vec_t;
endpackage

`default_nettype wire

// File: rtl/rd_pend_tracker_if.sv
// ----------------------------------------------------------------------------
// rd_pend_tracker_if: enqueue, pending bitmap and grant bus of the tracker.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rd_pend_tracker_if
  import rd_sched_pkg::*;
#(
  parameter int WIDTH = QUEUE_NUM
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] enq_i;
  logic [WIDTH-1:0] pend_o;
  logic             grant_valid_i;
  logic [IDX_W-1:0] grant_idx_i;
  logic             grant_ready_o;
  logic             sel_valid_o;
  logic [WIDTH-1:0] sel_onehot_o;
  logic             ovf_o;
  logic             err_o;

  // Scheduler / encoder side.
  modport master (
    output enq_i, grant_valid_i, grant_idx_i,
    input  pend_o, grant_ready_o, sel_valid_o, sel_onehot_o, ovf_o, err_o
  );

  // Tracker side.
  modport slave (
    input  enq_i, grant_valid_i, grant_idx_i,
    output pend_o, grant_ready_o, sel_valid_o, sel_onehot_o, ovf_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/idx_decoder.sv
// ----------------------------------------------------------------------------
// idx_decoder: binary index to one-hot, with a flag for index < WIDTH.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module idx_decoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic             in_range_o
);

  // Out-of-range indices decode to all zeros.
  always_comb begin
    onehot_o   = '0;
    in_range_o = (int'(idx_i) < WIDTH);
    for (int q = 0; q < WIDTH; q++) begin
      onehot_o[q] = (int'(idx_i) == q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rd_pend_tracker.sv
// ----------------------------------------------------------------------------
// rd_pend_tracker: per-queue saturating pending counters, pending bitmap and
// grant retirement with one-hot selection. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rd_pend_tracker
  import rd_sched_pkg::*;
#(
  parameter int WIDTH   = QUEUE_NUM,
  parameter int DEPTH_W = PEND_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  rd_pend_tracker_if.slave   bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [DEPTH_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] gnt_onehot;
  logic             gnt_in_range;
  logic [WIDTH-1:0] cnt_nz;
  logic [WIDTH-1:0] cnt_nz_d;
  logic [WIDTH-1:0] ovf_vec;
  logic [WIDTH-1:0] gnt_dec;
  logic             gnt_accept;
  logic             gnt_reject;

  logic             ready_q;
  logic [WIDTH-1:0] pend_q;
  logic             sel_valid_q;
  logic [WIDTH-1:0] sel_onehot_q;
  logic             ovf_q;
  logic             err_q;

  idx_decoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_idx_decoder (
    .idx_i      (bus.grant_idx_i),
    .onehot_o   (gnt_onehot),
    .in_range_o (gnt_in_range)
  );

  // Acceptance uses the pre-update counts, so same-cycle enqueues never rescue a grant.
  assign gnt_accept = bus.grant_valid_i & ready_q & gnt_in_range & (|(gnt_onehot & cnt_nz));
  assign gnt_reject = bus.grant_valid_i & ready_q & ~gnt_accept;
  assign gnt_dec    = gnt_accept ? gnt_onehot : '0;

  for (genvar q = 0; q < WIDTH; q++) begin : g_cnt
    logic [DEPTH_W-1:0] cnt_q;
    logic [DEPTH_W-1:0] cnt_d;
    logic               inc;
    logic               dec;
    logic               ovf;

    assign inc = bus.enq_i[q];
    assign dec = gnt_dec[q];

    always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      if (inc && !dec) begin
        if (cnt_q == CNT_MAX) begin
          ovf = 1'b1;
        end else begin
          cnt_d = cnt_q + DEPTH_W'(1);
        end
      end else if (dec && !inc) begin
        cnt_d = cnt_q - DEPTH_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_nz[q]   = (cnt_q != '0);
    assign cnt_nz_d[q] = (cnt_d != '0);
    assign ovf_vec[q]  = ovf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q      <= 1'b0;
      pend_q       <= '0;
      sel_valid_q  <= 1'b0;
      sel_onehot_q <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      pend_q       <= cnt_nz_d;
      sel_valid_q  <= gnt_accept;
      sel_onehot_q <= gnt_dec;
      ovf_q        <= |ovf_vec;
      err_q        <= gnt_reject;
    end
  end

  assign bus.grant_ready_o = ready_q;
  assign bus.pend_o        = pend_q;
  assign bus.sel_valid_o   = sel_valid_q;
  assign bus.sel_onehot_o  = sel_onehot_q;
  assign bus.ovf_o         = ovf_q;
  assign bus.err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_pend_tracker.sv
// ----------------------------------------------------------------------------
// tb_rd_pend_tracker: scoreboard bench for an 8-queue and a 6-queue tracker.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rd_pend_tracker;
  import rd_sched_pkg::*;

  typedef struct {
    logic [7:0] pend;
    logic       sv;
    logic [7:0] oh;
    logic       ovf;
    logic       err;
    logic       rdy;
  } exp_t;

  logic clk;
  logic rst_n;

  rd_pend_tracker_if #(.WIDTH(8)) bus8 ();
  rd_pend_tracker_if #(.WIDTH(6)) bus6 ();

  rd_pend_tracker #(.WIDTH(8), .DEPTH_W(4)) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus8)
  );

  rd_pend_tracker #(.WIDTH(6), .DEPTH_W(4)) u_dut6 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q8[$];
  exp_t q6[$];
  int   cnt_m [2][8];
  bit   rdy_m [2];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: each queue is a counter of packets in [0,15]; a grant retires one.
  function automatic exp_t model(int i, int w, logic [7:0] enq, logic gv, int gidx);
    exp_t e;
    bit   acc, rej, ovf;
    acc = gv && rdy_m[i] && (gidx < w) && (cnt_m[i][gidx] > 0);
    rej = gv && rdy_m[i] && !acc;
    ovf = 0;
    for (int q = 0; q < w; q++) begin
      bit inc, dec;
      inc = enq[q];
      dec = acc && (gidx == q);
      if (inc && !dec) begin
        if (cnt_m[i][q] == 15) ovf = 1;
        else cnt_m[i][q] = cnt_m[i][q] + 1;
      end else if (dec && !inc) begin
        cnt_m[i][q] = cnt_m[i][q] - 1;
      end
    end
    e.pend = '0;
    for (int q = 0; q < w; q++) e.pend[q] = (cnt_m[i][q] > 0);
    e.sv   = acc;
    e.oh   = acc ? 8'(1 << gidx) : 8'h00;
    e.ovf  = ovf;
    e.err  = rej;
    e.rdy  = 1'b1;
    rdy_m[i] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rdy_m[i] = 1'b0;
      for (int q = 0; q < 8; q++) cnt_m[i][q] = 0;
    end
  endtask

  task automatic cyc(logic [7:0] e8, logic v8, int g8, logic [5:0] e6, logic v6, int g6);
    @(negedge clk);
    bus8.enq_i         = e8;
    bus8.grant_valid_i = v8;
    bus8.grant_idx_i   = 3'(g8);
    bus6.enq_i         = e6;
    bus6.grant_valid_i = v6;
    bus6.grant_idx_i   = 3'(g6);
    q8.push_back(model(0, 8, e8, v8, g8));
    q6.push_back(model(1, 6, {2'b00, e6}, v6, g6));
  endtask

  task automatic cyc8(logic [7:0] e, logic v, int g);
    cyc(e, v, g, 6'h00, 1'b0, 0);
  endtask

  task automatic cyc6(logic [5:0] e, logic v, int g);
    cyc(8'h00, 1'b0, 0, e, v, g);
  endtask

  task automatic rand_cyc(int p_enq);
    logic [7:0] e8;
    logic [5:0] e6;
    for (int q = 0; q < 8; q++) e8[q] = ($urandom_range(0, 99) < p_enq);
    for (int q = 0; q < 6; q++) e6[q] = ($urandom_range(0, 99) < p_enq);
    cyc(e8, ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)),
        e6, ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " pend8"}, bus8.pend_o, 8'h00);
    chk({tag, " sel8"},  {5'b0, bus8.sel_valid_o, bus8.ovf_o, bus8.err_o}, 8'h00);
    chk({tag, " oh8"},   bus8.sel_onehot_o, 8'h00);
    chk({tag, " rdy8"},  {7'b0, bus8.grant_ready_o}, 8'h00);
    chk({tag, " pend6"}, {2'b0, bus6.pend_o}, 8'h00);
    chk({tag, " sel6"},  {5'b0, bus6.sel_valid_o, bus6.ovf_o, bus6.err_o}, 8'h00);
    chk({tag, " oh6"},   {2'b0, bus6.sel_onehot_o}, 8'h00);
    chk({tag, " rdy6"},  {7'b0, bus6.grant_ready_o}, 8'h00);
  endtask

  // Asynchronous assert mid-cycle, release between edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("rdy8 before edge", {7'b0, bus8.grant_ready_o}, 8'h00);
    chk("rdy6 before edge", {7'b0, bus6.grant_ready_o}, 8'h00);
  endtask

  // Monitor: pops one expected response per clock edge and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("pend8",  bus8.pend_o, e.pend);
        chk("sv8",    {7'b0, bus8.sel_valid_o}, {7'b0, e.sv});
        chk("oh8",    bus8.sel_onehot_o, e.oh);
        chk("ovf8",   {7'b0, bus8.ovf_o}, {7'b0, e.ovf});
        chk("err8",   {7'b0, bus8.err_o}, {7'b0, e.err});
        chk("rdy8",   {7'b0, bus8.grant_ready_o}, {7'b0, e.rdy});
      end
      if (q6.size() > 0) begin
        e = q6.pop_front();
        chk("pend6",  {2'b0, bus6.pend_o}, e.pend);
        chk("sv6",    {7'b0, bus6.sel_valid_o}, {7'b0, e.sv});
        chk("oh6",    {2'b0, bus6.sel_onehot_o}, e.oh);
        chk("ovf6",   {7'b0, bus6.ovf_o}, {7'b0, e.ovf});
        chk("err6",   {7'b0, bus6.err_o}, {7'b0, e.err});
        chk("rdy6",   {7'b0, bus6.grant_ready_o}, {7'b0, e.rdy});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus8.enq_i         = '0;
    bus8.grant_valid_i = 1'b0;
    bus8.grant_idx_i   = '0;
    bus6.enq_i         = '0;
    bus6.grant_valid_i = 1'b0;
    bus6.grant_idx_i   = '0;
    model_reset();
    #1;
    chk_all_zero("por");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("rdy8 por release", {7'b0, bus8.grant_ready_o}, 8'h00);

    // Grant in the first cycle after release is not yet accepted.
    cyc8(8'h00, 1'b1, 0);

    // Three strobes on queues 0 and 2, then drain.
    repeat (3) cyc8(8'h05, 1'b0, 0);
    repeat (3) cyc8(8'h00, 1'b1, 0);
    repeat (2) cyc8(8'h00, 1'b1, 2);
    cyc8(8'h00, 1'b1, 2);
    cyc8(8'h00, 1'b0, 0);

    // Stale re-grant on a just-emptied queue.
    cyc8(8'h02, 1'b0, 0);
    cyc8(8'h00, 1'b1, 1);
    cyc8(8'h00, 1'b1, 1);

    // Saturate queue 3, overflow, then enqueue with simultaneous grant.
    repeat (15) cyc8(8'h08, 1'b0, 0);
    cyc8(8'h08, 1'b0, 0);
    cyc8(8'h08, 1'b1, 3);
    cyc8(8'h00, 1'b0, 0);

    // Grant to empty queue 5 with a same-cycle enqueue, then a valid grant.
    cyc8(8'h20, 1'b1, 5);
    cyc8(8'h00, 1'b1, 5);
    cyc8(8'h00, 1'b0, 0);

    // 6-queue instance: out-of-range indices 6 and 7.
    cyc6(6'h3F, 1'b0, 0);
    cyc6(6'h00, 1'b1, 7);
    cyc6(6'h00, 1'b1, 6);
    cyc6(6'h00, 1'b1, 5);
    cyc6(6'h00, 1'b0, 0);

    // Reset in the middle of random traffic.
    repeat (60) rand_cyc(50);
    do_reset();
    cyc8(8'h01, 1'b1, 0);
    cyc8(8'h00, 1'b1, 0);

    // Alternate sparse and dense enqueue phases to reach both empty and full.
    for (int ph = 0; ph < 10; ph++) begin
      repeat (1000) rand_cyc((ph % 2 == 1) ? 75 : 15);
    end

    @(posedge clk);
    #2;
    n_chk++;
    if (q8.size() != 0 || q6.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending entries expected 0/0", q8.size(), q6.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
